// File: rtl/ram_arb_pkg.sv
// Shared opcodes and FSM encoding for the RAM request arbiter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package ram_arb_pkg;

    // RAM command opcodes, carried in ram_din[ADDR_WIDTH+1:ADDR_WIDTH]
    localparam logic [1:0] OP_WR_ADDR = 2'b00;
    localparam logic [1:0] OP_WR_DATA = 2'b01;
    localparam logic [1:0] OP_RD_ADDR = 2'b10;
    localparam logic [1:0] OP_RD_DATA = 2'b11;

    // One transaction walks IDLE -> ADDR -> DATA -> (WAIT) -> RESP -> IDLE
    typedef enum logic [2:0] {
        IDLE = 3'd0,
        ADDR = 3'd1,
        DATA = 3'd2,
        WAIT = 3'd3,
        RESP = 3'd4
    } state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin grant: first requesting index at or after the pointer, wrapping.
// Latency: combinational.
// Backpressure: none; the parent only samples the grant while idle.
module rr_arbiter #(
    parameter  int NUM_REQ = 2,
    localparam int ID_W    = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] i_req,
    input  logic [ID_W-1:0]    i_ptr,
    output logic [NUM_REQ-1:0] o_gnt,
    output logic [ID_W-1:0]    o_gnt_idx,
    output logic               o_any
);

    logic            w_found;
    logic [31:0]     w_scan;
    logic [ID_W-1:0] w_idx;

    // Scan from the pointer upward with wrap-around and keep the first hit.
    always_comb begin
        o_gnt     = '0;
        o_gnt_idx = '0;
        o_any     = |i_req;
        w_found   = 1'b0;
        w_scan    = '0;
        w_idx     = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            w_scan = (32'(i_ptr) + 32'(k)) % 32'(NUM_REQ);
            w_idx  = w_scan[ID_W-1:0];
            if (!w_found && i_req[w_idx]) begin
                w_found      = 1'b1;
                o_gnt[w_idx] = 1'b1;
                o_gnt_idx    = w_idx;
            end
        end
    end

endmodule

// File: rtl/ram_req_arbiter.sv
// Grants one requester a whole RAM transaction and serialises it into two RAM command beats.
// Latency: accept at T -> write response T+3, read response one cycle after ram_tx_valid (T+4 with a 1-cycle RAM).
// Backpressure: one transaction in flight; req_ready is only pulsed from IDLE, others hold req_valid.
module ram_req_arbiter
    import ram_arb_pkg::*;
#(
    parameter  int NUM_REQ    = 2,
    parameter  int ADDR_WIDTH = 8,
    parameter  int DATA_WIDTH = 8,
    parameter  int RD_TIMEOUT = 8,
    localparam int ID_W       = $clog2(NUM_REQ)
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [NUM_REQ-1:0]             req_valid,
    output logic [NUM_REQ-1:0]             req_ready,
    input  logic [NUM_REQ-1:0]             req_wr,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0]  req_addr,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]  req_wdata,
    output logic                           rsp_valid,
    output logic [ID_W-1:0]                rsp_id,
    output logic [DATA_WIDTH-1:0]          rsp_rdata,
    output logic                           rsp_err,
    output logic [ADDR_WIDTH+1:0]          ram_din,
    output logic                           ram_rx_valid,
    input  logic [DATA_WIDTH-1:0]          ram_dout,
    input  logic                           ram_tx_valid
);

    localparam int TMR_W = $clog2(RD_TIMEOUT) + 1;

    state_t                  r_state;
    state_t                  w_state_nxt;
    logic [ID_W-1:0]         r_ptr;
    logic                    r_wr;
    logic [ADDR_WIDTH-1:0]   r_addr;
    logic [DATA_WIDTH-1:0]   r_wdata;
    logic [ID_W-1:0]         r_id;
    logic [TMR_W-1:0]        r_timer;
    logic [NUM_REQ-1:0]      r_req_ready;
    logic [ADDR_WIDTH+1:0]   r_ram_din;
    logic                    r_ram_rx_valid;
    logic                    r_rsp_valid;
    logic [ID_W-1:0]         r_rsp_id;
    logic [DATA_WIDTH-1:0]   r_rsp_rdata;
    logic                    r_rsp_err;

    logic [NUM_REQ-1:0]      w_gnt;
    logic [ID_W-1:0]         w_gnt_idx;
    logic                    w_any;
    logic                    w_sel_wr;
    logic [ADDR_WIDTH-1:0]   w_sel_addr;
    logic [DATA_WIDTH-1:0]   w_sel_wdata;

    logic [NUM_REQ-1:0]      w_req_ready_nxt;
    logic [ADDR_WIDTH+1:0]   w_ram_din_nxt;
    logic                    w_ram_rx_valid_nxt;
    logic                    w_rsp_valid_nxt;
    logic                    w_rsp_load;
    logic [DATA_WIDTH-1:0]   w_rsp_rdata_nxt;
    logic                    w_rsp_err_nxt;
    logic                    w_latch;
    logic                    w_timer_clr;
    logic                    w_timer_inc;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) u_rr (
        .i_req     (req_valid),
        .i_ptr     (r_ptr),
        .o_gnt     (w_gnt),
        .o_gnt_idx (w_gnt_idx),
        .o_any     (w_any)
    );

    // One-hot mux of the granted requester's fields (constant indices only).
    always_comb begin
        w_sel_wr    = |(req_wr & w_gnt);
        w_sel_addr  = '0;
        w_sel_wdata = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_gnt[i]) begin
                w_sel_addr  = req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
                w_sel_wdata = req_wdata[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state and next values of every registered output.
    // The response is loaded on the cycle the last RAM event completes, so it
    // appears one cycle after the write-data beat or after ram_tx_valid.
    always_comb begin
        w_state_nxt        = r_state;
        w_req_ready_nxt    = '0;
        w_ram_din_nxt      = '0;
        w_ram_rx_valid_nxt = 1'b0;
        w_rsp_valid_nxt    = 1'b0;
        w_rsp_load         = 1'b0;
        w_rsp_rdata_nxt    = '0;
        w_rsp_err_nxt      = 1'b0;
        w_latch            = 1'b0;
        w_timer_clr        = 1'b0;
        w_timer_inc        = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_any) begin
                    w_req_ready_nxt = w_gnt;
                    w_latch         = 1'b1;
                    w_state_nxt     = ADDR;
                end
            end
            ADDR: begin
                w_ram_rx_valid_nxt = 1'b1;
                w_ram_din_nxt      = {(r_wr ? OP_WR_ADDR : OP_RD_ADDR), r_addr};
                w_state_nxt        = DATA;
            end
            DATA: begin
                w_ram_rx_valid_nxt = 1'b1;
                w_ram_din_nxt      = r_wr ? {OP_WR_DATA, ADDR_WIDTH'(r_wdata)}
                                          : {OP_RD_DATA, {ADDR_WIDTH{1'b0}}};
                w_timer_clr        = 1'b1;
                w_state_nxt        = r_wr ? RESP : WAIT;
            end
            WAIT: begin
                if (ram_tx_valid) begin
                    w_rsp_valid_nxt = 1'b1;
                    w_rsp_load      = 1'b1;
                    w_rsp_rdata_nxt = ram_dout;
                    w_state_nxt     = RESP;
                end else if (r_timer == TMR_W'(RD_TIMEOUT - 1)) begin
                    w_rsp_valid_nxt = 1'b1;
                    w_rsp_load      = 1'b1;
                    w_rsp_err_nxt   = 1'b1;
                    w_state_nxt     = RESP;
                end else begin
                    w_timer_inc = 1'b1;
                end
            end
            RESP: begin
                // Reads already issued their response on the way in.
                if (r_wr) begin
                    w_rsp_valid_nxt = 1'b1;
                    w_rsp_load      = 1'b1;
                end
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // Pointer, latched request, read timer and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ptr          <= '0;
            r_wr           <= 1'b0;
            r_addr         <= '0;
            r_wdata        <= '0;
            r_id           <= '0;
            r_timer        <= '0;
            r_req_ready    <= '0;
            r_ram_din      <= '0;
            r_ram_rx_valid <= 1'b0;
            r_rsp_valid    <= 1'b0;
            r_rsp_id       <= '0;
            r_rsp_rdata    <= '0;
            r_rsp_err      <= 1'b0;
        end else begin
            r_req_ready    <= w_req_ready_nxt;
            r_ram_din      <= w_ram_din_nxt;
            r_ram_rx_valid <= w_ram_rx_valid_nxt;
            r_rsp_valid    <= w_rsp_valid_nxt;
            if (w_latch) begin
                r_wr    <= w_sel_wr;
                r_addr  <= w_sel_addr;
                r_wdata <= w_sel_wdata;
                r_id    <= w_gnt_idx;
                r_ptr   <= (w_gnt_idx == ID_W'(NUM_REQ - 1)) ? '0 : w_gnt_idx + ID_W'(1);
            end
            if (w_timer_clr) begin
                r_timer <= '0;
            end else if (w_timer_inc) begin
                r_timer <= r_timer + TMR_W'(1);
            end
            if (w_rsp_load) begin
                r_rsp_id    <= r_id;
                r_rsp_rdata <= w_rsp_rdata_nxt;
                r_rsp_err   <= w_rsp_err_nxt;
            end
        end
    end

    assign req_ready    = r_req_ready;
    assign ram_din      = r_ram_din;
    assign ram_rx_valid = r_ram_rx_valid;
    assign rsp_valid    = r_rsp_valid;
    assign rsp_id       = r_rsp_id;
    assign rsp_rdata    = r_rsp_rdata;
    assign rsp_err      = r_rsp_err;

endmodule
